apb_slave_regfile: RTL

//  APB responder: the completer end of the APB bus driven by the AHB-to-APB bridge controller.

---
 rtl/apb_slave_regfile_pkg.sv | 30 +++
 rtl/apb_proto_chk.sv | 69 ++++++
 rtl/apb_slave_regfile.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/apb_slave_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_regfile_pkg
//  Purpose  : Shared APB completer definitions: FSM encodings, select width,
//             default slave address map and the address-decode helper.
//  Revision : 1.0
// ============================================================================
package apb_slave_regfile_pkg;

    localparam int c_psel_w = 3;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'b00,
        APB_SETUP  = 2'b01,
        APB_ACCESS = 2'b10
    } apb_state_t;

    localparam logic [31:0] c_slv0_base = 32'h8000_0000;
    localparam logic [31:0] c_slv1_base = 32'h8400_0000;
    localparam logic [31:0] c_slv2_base = 32'h8800_0000;

    // Base is aligned to the window span, so a masked compare is a range check.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] span);
        return ((addr & ~(span - 32'd1)) == base) && (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_proto_chk.sv
`default_nettype none
// ============================================================================
//  Module   : apb_proto_chk
//  Purpose  : Captures the SETUP-phase control/data of an APB transfer and
//             flags access-phase protocol violations with a sticky error bit.
//  Revision : 1.0
// ============================================================================
module apb_proto_chk #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_capture,
    input  logic          i_check,
    input  logic          i_ready,
    input  logic          i_sel,
    input  logic          i_penable,
    input  logic          i_idle_err,
    input  logic [AW-1:0] i_addr,
    input  logic          i_write,
    input  logic [DW-1:0] i_wdata,
    output logic [AW-1:0] o_addr,
    output logic          o_write,
    output logic [DW-1:0] o_wdata,
    output logic          o_viol,
    output logic          o_prot_err
);

    logic [AW-1:0] r_addr;
    logic          r_write;
    logic [DW-1:0] r_wdata;
    logic          r_prot_err;
    logic          w_held;
    logic          w_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (i_capture) begin
            r_addr  <= i_addr;
            r_write <= i_write;
            r_wdata <= i_wdata;
        end
    end

    assign w_held     = i_sel && i_penable;
    assign w_mismatch = (i_addr != r_addr) || (i_write != r_write) || (i_wdata != r_wdata);

    // A released bus is only illegal while the completer is still inserting waits.
    assign o_viol = i_check && (w_held ? w_mismatch : !i_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prot_err <= 1'b0;
        end else if (o_viol || i_idle_err) begin
            r_prot_err <= 1'b1;
        end
    end

    assign o_addr     = r_addr;
    assign o_write    = r_write;
    assign o_wdata    = r_wdata;
    assign o_prot_err = r_prot_err;

endmodule
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_regfile
//  Purpose  : APB completer serving a zero-initialised 32-bit register file,
//             with programmable wait states and a sticky protocol-error flag.
//  Revision : 1.0
// ============================================================================
module apb_slave_regfile
    import apb_slave_regfile_pkg::*;
#(
    parameter int          SEL_BIT     = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic [c_psel_w-1:0] pselx,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [31:0]         paddr,
    input  logic [31:0]         pwdata,
    output logic [31:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    output logic                prot_err
);

    localparam int          c_idx_w = $clog2(DEPTH);
    localparam logic [31:0] c_span  = 32'(DEPTH * 4);
    localparam logic [3:0]  c_wait  = 4'(WAIT_STATES);

    apb_state_t         r_state;
    apb_state_t         w_phase;
    apb_state_t         w_next;
    logic [31:0]        r_regs [DEPTH];
    logic [31:0]        r_prdata;
    logic [3:0]         r_wcnt;

    logic               w_sel;
    logic               w_unused_psel;
    logic               w_setup;
    logic               w_access;
    logic               w_ready;
    logic               w_idle_err;
    logic               w_viol;
    logic               w_complete;
    logic               w_commit;
    logic               w_rd_hit;
    logic               w_lat_hit;
    logic [c_idx_w-1:0] w_rd_idx;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [31:0]        w_lat_addr;
    logic               w_lat_write;
    logic [31:0]        w_lat_wdata;

    assign w_sel         = pselx[SEL_BIT];
    assign w_unused_psel = ^pselx;

    assign w_rd_hit  = addr_hit(paddr, BASE_ADDR, c_span);
    assign w_rd_idx  = paddr[c_idx_w+1:2];
    assign w_lat_hit = addr_hit(w_lat_addr, BASE_ADDR, c_span);
    assign w_wr_idx  = w_lat_addr[c_idx_w+1:2];

    // The register only ever rests in IDLE or ACCESS; SETUP is the phase of the
    // cycle in which an idle slave sees a new select without penable.
    always_comb begin
        w_phase    = r_state;
        w_next     = APB_IDLE;
        w_ready    = 1'b1;
        w_idle_err = 1'b0;
        if (r_state == APB_IDLE && w_sel && !penable) begin
            w_phase = APB_SETUP;
        end
        w_setup  = (w_phase == APB_SETUP);
        w_access = (w_phase == APB_ACCESS);
        if (w_access) begin
            w_ready = (r_wcnt == c_wait);
        end
        case (w_phase)
            APB_IDLE: begin
                w_idle_err = w_sel && penable;
                w_next     = APB_IDLE;
            end
            APB_SETUP: begin
                w_next = APB_ACCESS;
            end
            APB_ACCESS: begin
                w_next = (w_viol || w_ready) ? APB_IDLE : APB_ACCESS;
            end
            default: begin
                w_next = APB_IDLE;
            end
        endcase
    end

    assign w_complete = w_access && w_ready && w_sel && penable && !w_viol;
    assign w_commit   = w_complete && w_lat_write && w_lat_hit;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state  <= APB_IDLE;
            r_wcnt   <= '0;
            r_prdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_setup) begin
                r_wcnt <= '0;
                if (!pwrite) begin
                    r_prdata <= w_rd_hit ? r_regs[w_rd_idx] : 32'd0;
                end
            end else if (w_access && !w_ready && !w_viol) begin
                r_wcnt <= r_wcnt + 4'd1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[w_wr_idx] <= w_lat_wdata;
        end
    end

    apb_proto_chk #(
        .AW (32),
        .DW (32)
    ) u_proto_chk (
        .clk        (hclk),
        .rst        (hreset),
        .i_capture  (w_setup),
        .i_check    (w_access),
        .i_ready    (w_ready),
        .i_sel      (w_sel),
        .i_penable  (penable),
        .i_idle_err (w_idle_err),
        .i_addr     (paddr),
        .i_write    (pwrite),
        .i_wdata    (pwdata),
        .o_addr     (w_lat_addr),
        .o_write    (w_lat_write),
        .o_wdata    (w_lat_wdata),
        .o_viol     (w_viol),
        .o_prot_err (prot_err)
    );

    assign prdata  = r_prdata;
    assign pready  = w_ready;
    assign pslverr = w_access && w_ready && !w_lat_hit;

endmodule
`default_nettype wire
